serial_adder: RTL and testbench



---
 rtl/serial_adder_fa.sv | 17 +
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell.
// Combinational slice sequenced by serial_adder.
module FullAdder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic S,
   output logic Cout
);

   // Sum and carry of one bit position
   always_comb begin
      S    = a ^ b ^ c;
      Cout = (a & b) | (c & (a ^ b));
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder controller, LSB first.
// One FullAdder cell plus a registered carry replace a ripple chain.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic fa_s;
   logic fa_cout;

   FullAdder u_fa (
      .a    (sa_q[0]),
      .b    (sb_q[0]),
      .c    (carry_q),
      .S    (fa_s),
      .Cout (fa_cout)
   );

   // Next-state, shift datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sa_d    = op_a;
               sb_d    = op_b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            carry_d = fa_cout;
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               cout_d  = fa_cout;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == SHIFT) || (state_d == DONE);
      done_d = (state_d == DONE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8).
// Directed and random adds against an arithmetic reference.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int tests = 0;
   int fails = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op_a  (op_a),
      .op_b  (op_b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one add and follow it to the first IDLE cycle after done.
   // inj: re-request a different add while busy (must be ignored).
   task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input bit inj, input string tag);
      logic [W:0] exp;
      int k;
      int busy_n;
      exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      cin   = c;
      tick();
      start = 1'b0;
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      cin   = 1'($urandom);
      k = 0;
      busy_n = 0;
      while (!done && k < 30) begin
         if (busy) busy_n++;
         if (inj && (k == 2 || k == 3)) begin
            start = 1'b1;
            op_a  = 8'hAA;
            op_b  = 8'h55;
         end else begin
            start = 1'b0;
         end
         tick();
         k++;
      end
      start = 1'b0;
      check({tag, "_latency"}, 32'(k), 32'(W));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
      check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      check({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
      check({tag, "_cout"}, 32'(cout), 32'(exp[W]));
      tick();
      check({tag, "_done_width"}, 32'(done), 32'd0);
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
      check({tag, "_sum_hold"}, 32'({cout, sum}), 32'(exp));
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      int           seen;

      rst = 1'b1;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      rst = 1'b0;
      tick();
      check("idle_no_start", 32'(busy), 32'd0);

      do_add(8'h5A, 8'h3C, 1'b0, 1'b0, "t1");
      do_add(8'hFF, 8'h01, 1'b0, 1'b0, "t2");
      do_add(8'hFF, 8'hFF, 1'b1, 1'b0, "t3");
      do_add(8'h10, 8'h20, 1'b0, 1'b1, "t4");

      // reset during the fourth SHIFT cycle abandons the add
      start = 1'b1;
      op_a  = 8'h80;
      op_b  = 8'h80;
      cin   = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_sum", 32'(sum), 32'd0);
      check("t5_cout", 32'(cout), 32'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) seen++;
         tick();
      end
      check("t5_no_done", 32'(seen), 32'd0);
      do_add(8'h01, 8'h02, 1'b0, 1'b0, "t5_fresh");

      // back-to-back random adds, each started in the first IDLE cycle
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         do_add(ra, rb, rc, 1'b0, "t6");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
